axi4_lite_read_master_engine: RTL and testbench
===============================================

Name: axi4_lite_read_master_engine

Overview:
- RTL AXI4-Lite read initiator: the requesting end of the read-address (AR) and read-data (R) channels; our read-slave VIP answers it.
- Accepts one read command on a valid/ready command port and issues it on AR.
- Collects the R beat and returns data and response on a valid/ready response port.
- One transaction outstanding at a time. Sits between a local requester and the AXI4-Lite read slave.

Parameters:
- ADDRESS_WIDTH, 32, width of araddr and cmd_addr
- DATA_WIDTH, 32, width of rdata and rsp_data
- DELAY_WIDTH, 5, width of the rready delay field
- MIN_ADDRESS, 32'h0000_0000, lowest legal address (inclusive)
- MAX_ADDRESS, 32'hffff_ffff, highest legal address (inclusive)

Ports:
- aclk  in  1  clock; all logic on the rising edge
- areset  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_addr  in  ADDRESS_WIDTH  read address
- cmd_prot  in  3  protection attribute
- cmd_rready_delay  in  DELAY_WIDTH  cycles to hold rready low (used only with the macro)
- araddr  out  ADDRESS_WIDTH  AR address
- arprot  out  3  AR protection
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rdata  in  DATA_WIDTH  R data
- rresp  in  2  R response
- rvalid  in  1  R valid
- rready  out  1  R ready
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts the response
- rsp_data  out  DATA_WIDTH  returned data
- rsp_resp  out  2  returned response (OKAY/EXOKAY/SLVERR/DECERR)
- rsp_local_err  out  1  response generated locally; no bus transaction was issued

Behaviour:
- Reset values (while areset high): state IDLE; arvalid 0; rready 0; rsp_valid 0; araddr 0; arprot 0; rsp_data 0; rsp_resp 0; rsp_local_err 0.
- cmd_ready = (state==IDLE) & ~areset, so cmd_ready is 0 during reset.
- Reset asserted mid-transaction: all outputs return to reset values immediately; the in-flight read is dropped and no response is produced.
- States: IDLE, ADDR, DATA, RESP.
- IDLE, on cmd_valid & cmd_ready: latch cmd_addr, cmd_prot, cmd_rready_delay.
  - MIN_ADDRESS <= addr <= MAX_ADDRESS: go to ADDR; arvalid=1 from the next cycle.
  - Otherwise: go to RESP with rsp_resp=2'b11, rsp_data=0, rsp_local_err=1. Nothing appears on AR.
- ADDR: arvalid held high; araddr and arprot stable until arready is sampled high.
  - On the handshake edge: arvalid←0, go to DATA, rready←1.
  - arready already high when arvalid rises is legal (one-cycle handshake).
  - arready may toggle freely; no handshake without arvalid & arready.
- DATA, on rvalid & rready:
  - Capture rdata into rsp_data and rresp into rsp_resp, unchanged; all four codes pass through.
  - rsp_local_err←0, rready←0, go to RESP.
  - rvalid seen in any other state is ignored (rready is low).
- RESP: rsp_valid high; rsp_data, rsp_resp and rsp_local_err stable until rsp_ready is sampled high, then go to IDLE.
  - A new command can be accepted in the cycle after the response handshake.
- Latency with a zero-wait slave (AR handshake and R beat each completing on the first cycle they are offered): command handshake edge N → arvalid from N+1 → rready from N+2 → rsp_valid from N+3.
- Local DECERR path: rsp_valid from N+1.

Optional Feature:
- Macro: AXI4LITE_READ_MASTER_RREADY_DELAY_EN.
- Defined: on entry to DATA, a down-counter loads the latched delay. rready stays 0 while counter≠0 and rises the cycle the counter reaches 0. Delay 0 behaves exactly like the undefined case. Counter reset value is 0.
- Undefined: no counter; cmd_rready_delay is ignored; rready rises on the AR handshake edge.

Decomposition:
- Shared package axi4_lite_read_master_pkg holds:
  - ADDRESS_WIDTH, DATA_WIDTH, DELAY_WIDTH, MIN_ADDRESS, MAX_ADDRESS defaults
  - rresp enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - arprot enum (3-bit secure/privileged/instruction encodings)
  - state enum readMasterStateEnum {IDLE, ADDR, DATA, RESP}
- One natural sub-module: axi4_lite_rready_delay_counter (load, decrement, zero flag), instantiated only under the macro.

Test Plan:
- Zero-wait read: cmd addr 0x0000_1000, prot 3'b010; slave arready=1, rvalid with rdata 0xDEAD_BEEF, rresp 0 → araddr 0x1000 and arprot 3'b010 on AR; rsp_valid at N+3 with data 0xDEAD_BEEF, resp 0, local_err 0.
- Backpressure: arready held low 4 cycles, rvalid delayed 3 cycles, rsp_ready low 2 cycles → araddr/arvalid stable throughout; exactly one AR handshake and one R handshake; rsp fields stable until rsp_ready.
- Out of range: MIN_ADDRESS=0x100, MAX_ADDRESS=0x1FF, cmd addr 0x200 → arvalid never rises; rsp_valid at N+1 with resp 3, data 0, local_err 1.
- Error pass-through: slave returns rresp 2 then rresp 1 on back-to-back commands → rsp_resp 2 then 1; cmd_ready low until each response handshake completes.
- Reset mid-DATA: assert areset while rready=1 → arvalid, rready and rsp_valid drop to 0 asynchronously; after release, a new command completes normally.
- Macro defined, cmd_rready_delay=5 → rready rises exactly 5 cycles after the AR handshake edge; rvalid asserted early is held by the slave and captured then.

Source files
------------

// File: rtl/axi4_lite_read_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_master_pkg
// Purpose  : Shared defaults and type definitions for the AXI4-Lite read
//            master engine and its rready delay counter.
// Contents : default widths/address window, rresp and arprot encodings,
//            engine state enumeration.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_read_master_pkg;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_DELAY_WIDTH   = 5;
  localparam logic [31:0] DEFAULT_MIN_ADDRESS   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_MAX_ADDRESS   = 32'hffff_ffff;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } rresp_e;

  // Bit 0: privileged, bit 1: non-secure, bit 2: instruction.
  typedef enum logic [2:0] {
    PROT_DATA_SECURE_UNPRIV      = 3'b000,
    PROT_DATA_SECURE_PRIV        = 3'b001,
    PROT_DATA_NONSECURE_UNPRIV   = 3'b010,
    PROT_DATA_NONSECURE_PRIV     = 3'b011,
    PROT_INSTR_SECURE_UNPRIV     = 3'b100,
    PROT_INSTR_SECURE_PRIV       = 3'b101,
    PROT_INSTR_NONSECURE_UNPRIV  = 3'b110,
    PROT_INSTR_NONSECURE_PRIV    = 3'b111
  } arprot_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } readMasterStateEnum;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_rready_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_rready_delay_counter
// Purpose  : Saturating down-counter that holds rready low for a programmed
//            number of cycles after the AR handshake.
// Ports    : clk_i, rst_i (async, active-high), load_i, load_value_i,
//            zero_o (count has reached zero).
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_rready_delay_counter
  import axi4_lite_read_master_pkg::*;
#(
  parameter int unsigned DELAY_WIDTH = DEFAULT_DELAY_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [DELAY_WIDTH-1:0] load_value_i,
  output logic                   zero_o
);

  logic [DELAY_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - DELAY_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_read_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_read_master_engine
// Purpose  : AXI4-Lite read initiator. Accepts one command, issues it on AR,
//            collects the R beat and returns it on a response port. One
//            transaction outstanding; out-of-window addresses are answered
//            locally with DECERR and never reach the bus.
// Ports    : aclk/areset (async, active-high); cmd_* command port;
//            ar*/r* AXI4-Lite read channels; rsp_* response port.
// Options  : AXI4LITE_READ_MASTER_RREADY_DELAY_EN - hold rready low for
//            cmd_rready_delay cycles after the AR handshake.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_read_master_engine
  import axi4_lite_read_master_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned              DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned              DELAY_WIDTH   = DEFAULT_DELAY_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = ADDRESS_WIDTH'(DEFAULT_MIN_ADDRESS),
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = ADDRESS_WIDTH'(DEFAULT_MAX_ADDRESS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [2:0]               cmd_prot,
  input  logic [DELAY_WIDTH-1:0]   cmd_rready_delay,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_local_err
);

  // Window test as an offset compare keeps it a single unsigned comparison
  // that stays meaningful even when the window spans the whole address space.
  localparam logic [ADDRESS_WIDTH-1:0] c_SPAN = MAX_ADDRESS - MIN_ADDRESS;

  readMasterStateEnum       state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]               prot_q, prot_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [1:0]               resp_q, resp_d;
  logic                     local_err_q, local_err_d;
  logic                     w_in_range;
  logic                     w_rready_open;
  logic                     w_ar_hs;

  assign w_in_range = ((cmd_addr - MIN_ADDRESS) <= c_SPAN);
  assign w_ar_hs    = (state_q == ADDR) && arready;

`ifdef AXI4LITE_READ_MASTER_RREADY_DELAY_EN
  logic [DELAY_WIDTH-1:0] delay_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      delay_q <= '0;
    end else if (cmd_ready && cmd_valid) begin
      delay_q <= cmd_rready_delay;
    end
  end

  // Loaded on the AR handshake edge so the count starts on DATA entry.
  axi4_lite_rready_delay_counter #(
    .DELAY_WIDTH (DELAY_WIDTH)
  ) u_rready_delay (
    .clk_i        (aclk),
    .rst_i        (areset),
    .load_i       (w_ar_hs),
    .load_value_i (delay_q),
    .zero_o       (w_rready_open)
  );
`else
  logic w_delay_unused;
  assign w_delay_unused = ^cmd_rready_delay;
  assign w_rready_open  = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    prot_d      = prot_q;
    data_d      = data_q;
    resp_d      = resp_q;
    local_err_d = local_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          prot_d = cmd_prot;
          if (w_in_range) begin
            state_d = ADDR;
          end else begin
            state_d     = RESP;
            data_d      = '0;
            resp_d      = DECERR;
            local_err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid && w_rready_open) begin
          data_d      = rdata;
          resp_d      = rresp;
          local_err_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      prot_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      local_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      data_q      <= data_d;
      resp_q      <= resp_d;
      local_err_q <= local_err_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE) && !areset;
  assign araddr        = addr_q;
  assign arprot        = prot_q;
  assign arvalid       = (state_q == ADDR);
  assign rready        = (state_q == DATA) && w_rready_open;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_data      = data_q;
  assign rsp_resp      = resp_q;
  assign rsp_local_err = local_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_read_master_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_read_master_engine
// Purpose  : Self-checking bench for axi4_lite_read_master_engine. Two
//            instances: full address window, and a narrow window
//            0x100..0x1FF for the local DECERR path. The bench plays the
//            requester and the read slave and predicts every output from a
//            transaction-level model.
// Options  : AXI4LITE_READ_MASTER_RREADY_DELAY_EN changes the expected rready
//            timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_read_master_engine;

  localparam logic [31:0] c_NARROW_MIN = 32'h0000_0100;
  localparam logic [31:0] c_NARROW_MAX = 32'h0000_01FF;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cur_sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_prot = '0;
  logic [4:0]  cmd_rready_delay = '0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rsp_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // per-instance outputs
  logic        cmd_ready0, cmd_ready1;
  logic [31:0] araddr0, araddr1;
  logic [2:0]  arprot0, arprot1;
  logic        arvalid0, arvalid1, rready0, rready1;
  logic        rsp_valid0, rsp_valid1;
  logic [31:0] rsp_data0, rsp_data1;
  logic [1:0]  rsp_resp0, rsp_resp1;
  logic        rsp_local_err0, rsp_local_err1;

  logic cmd_valid0, cmd_valid1, rsp_ready0, rsp_ready1;
  assign cmd_valid0 = cmd_valid & ~cur_sel;
  assign cmd_valid1 = cmd_valid &  cur_sel;
  assign rsp_ready0 = rsp_ready & ~cur_sel;
  assign rsp_ready1 = rsp_ready &  cur_sel;

  // observed view of the selected instance
  logic        m_cmd_ready, m_arvalid, m_rready, m_rsp_valid, m_rsp_local_err;
  logic [31:0] m_araddr, m_rsp_data;
  logic [2:0]  m_arprot;
  logic [1:0]  m_rsp_resp;
  assign m_cmd_ready     = cur_sel ? cmd_ready1     : cmd_ready0;
  assign m_arvalid       = cur_sel ? arvalid1       : arvalid0;
  assign m_rready        = cur_sel ? rready1        : rready0;
  assign m_rsp_valid     = cur_sel ? rsp_valid1     : rsp_valid0;
  assign m_rsp_local_err = cur_sel ? rsp_local_err1 : rsp_local_err0;
  assign m_araddr        = cur_sel ? araddr1        : araddr0;
  assign m_rsp_data      = cur_sel ? rsp_data1      : rsp_data0;
  assign m_arprot        = cur_sel ? arprot1        : arprot0;
  assign m_rsp_resp      = cur_sel ? rsp_resp1      : rsp_resp0;

  axi4_lite_read_master_engine dut (
    .aclk (aclk), .areset (areset),
    .cmd_valid (cmd_valid0), .cmd_ready (cmd_ready0), .cmd_addr (cmd_addr),
    .cmd_prot (cmd_prot), .cmd_rready_delay (cmd_rready_delay),
    .araddr (araddr0), .arprot (arprot0), .arvalid (arvalid0), .arready (arready),
    .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready0),
    .rsp_valid (rsp_valid0), .rsp_ready (rsp_ready0), .rsp_data (rsp_data0),
    .rsp_resp (rsp_resp0), .rsp_local_err (rsp_local_err0)
  );

  axi4_lite_read_master_engine #(
    .MIN_ADDRESS (c_NARROW_MIN),
    .MAX_ADDRESS (c_NARROW_MAX)
  ) dut_narrow (
    .aclk (aclk), .areset (areset),
    .cmd_valid (cmd_valid1), .cmd_ready (cmd_ready1), .cmd_addr (cmd_addr),
    .cmd_prot (cmd_prot), .cmd_rready_delay (cmd_rready_delay),
    .araddr (araddr1), .arprot (arprot1), .arvalid (arvalid1), .arready (arready),
    .rdata (rdata), .rresp (rresp), .rvalid (rvalid), .rready (rready1),
    .rsp_valid (rsp_valid1), .rsp_ready (rsp_ready1), .rsp_data (rsp_data1),
    .rsp_resp (rsp_resp1), .rsp_local_err (rsp_local_err1)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: window membership and effective rready hold-off.
  function automatic bit model_in_range(input bit sel, input logic [31:0] addr);
    if (sel) return (addr >= c_NARROW_MIN) && (addr <= c_NARROW_MAX);
    return 1'b1;
  endfunction

  function automatic int model_rready_delay(input logic [4:0] dly);
`ifdef AXI4LITE_READ_MASTER_RREADY_DELAY_EN
    return int'(dly);
`else
    return 0 * int'(dly);
`endif
  endfunction

  // One full transaction: requester + slave behaviour, checked cycle by cycle
  // at falling edges against the model's expected timeline.
  task automatic do_read(input bit sel, input logic [31:0] addr, input logic [2:0] prot,
                         input logic [4:0] dly, input int ar_wait, input int r_wait,
                         input int rsp_wait, input logic [31:0] data, input logic [1:0] resp);
    bit          local_err;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          eff;
    int          jhs;
    local_err = !model_in_range(sel, addr);
    exp_data  = local_err ? 32'h0 : data;
    exp_resp  = local_err ? 2'b11 : resp;
    eff       = model_rready_delay(dly);
    jhs       = (r_wait > eff) ? r_wait : eff;

    @(negedge aclk);
    cur_sel = sel;
    #1;
    check("cmd_ready_idle", {63'd0, m_cmd_ready}, 64'd1);
    cmd_valid        = 1'b1;
    cmd_addr         = addr;
    cmd_prot         = prot;
    cmd_rready_delay = dly;
    arready          = (ar_wait == 0);
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    check("cmd_ready_busy", {63'd0, m_cmd_ready}, 64'd0);

    if (local_err) begin
      arready = 1'b0;
      check("local_no_arvalid", {63'd0, m_arvalid}, 64'd0);
    end else begin
      for (int k = 0; k <= ar_wait; k++) begin
        if (k > 0) @(negedge aclk);
        check("arvalid", {63'd0, m_arvalid}, 64'd1);
        check("araddr", {32'd0, m_araddr}, {32'd0, addr});
        check("arprot", {61'd0, m_arprot}, {61'd0, prot});
        check("rready_in_addr", {63'd0, m_rready}, 64'd0);
        arready = (k == ar_wait);
        // stray R beats during the address phase must be ignored
        rvalid  = (k < ar_wait) ? 1'($urandom_range(0, 1)) : 1'b0;
        rdata   = $urandom;
      end
      @(negedge aclk);
      arready = 1'b0;
      check("arvalid_drop", {63'd0, m_arvalid}, 64'd0);
      for (int j = 0; j <= jhs; j++) begin
        if (j > 0) @(negedge aclk);
        check("rready", {63'd0, m_rready}, {63'd0, (j >= eff)});
        check("rsp_valid_early", {63'd0, m_rsp_valid}, 64'd0);
        rvalid = (j >= r_wait);
        rdata  = (j >= r_wait) ? data : $urandom;
        rresp  = (j >= r_wait) ? resp : 2'($urandom_range(0, 3));
      end
      @(negedge aclk);
      rvalid = 1'b0;
      rdata  = $urandom;
      check("rready_drop", {63'd0, m_rready}, 64'd0);
    end

    for (int i = 0; i <= rsp_wait; i++) begin
      if (i > 0) @(negedge aclk);
      check("rsp_valid", {63'd0, m_rsp_valid}, 64'd1);
      check("rsp_data", {32'd0, m_rsp_data}, {32'd0, exp_data});
      check("rsp_resp", {62'd0, m_rsp_resp}, {62'd0, exp_resp});
      check("rsp_local_err", {63'd0, m_rsp_local_err}, {63'd0, local_err});
      check("cmd_ready_rsp", {63'd0, m_cmd_ready}, 64'd0);
      rsp_ready = (i == rsp_wait);
    end
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {63'd0, m_rsp_valid}, 64'd0);
    check("cmd_ready_after", {63'd0, m_cmd_ready}, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", {63'd0, cmd_ready0}, 64'd0);
    check("rst_arvalid", {63'd0, arvalid0}, 64'd0);
    check("rst_rready", {63'd0, rready0}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid0}, 64'd0);
    check("rst_araddr", {32'd0, araddr0}, 64'd0);
    check("rst_arprot", {61'd0, arprot0}, 64'd0);
    check("rst_rsp_data", {32'd0, rsp_data0}, 64'd0);
    check("rst_rsp_resp", {62'd0, rsp_resp0}, 64'd0);
    check("rst_rsp_local_err", {63'd0, rsp_local_err0}, 64'd0);
    areset = 1'b0;

    // zero-wait read
    do_read(1'b0, 32'h0000_1000, 3'b010, 5'd0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00);
    // backpressure on every channel
    do_read(1'b0, 32'h0000_3000, 3'b101, 5'd0, 4, 3, 2, 32'hCAFE_F00D, 2'b00);
    // error pass-through, back to back
    do_read(1'b0, 32'h0000_4000, 3'b000, 5'd0, 0, 0, 0, 32'h1111_2222, 2'b10);
    do_read(1'b0, 32'h0000_4004, 3'b000, 5'd0, 1, 1, 1, 32'h3333_4444, 2'b01);
    do_read(1'b0, 32'hFFFF_FFFC, 3'b111, 5'd0, 0, 2, 0, 32'h5555_6666, 2'b11);
    // rready hold-off with an early rvalid
    do_read(1'b0, 32'h0000_2000, 3'b000, 5'd5, 0, 0, 0, 32'h1234_5678, 2'b00);

    // narrow window: out of range above/below, both inclusive bounds
    do_read(1'b1, 32'h0000_0200, 3'b001, 5'd0, 0, 0, 0, 32'hAAAA_AAAA, 2'b00);
    do_read(1'b1, 32'h0000_00FF, 3'b001, 5'd0, 0, 0, 1, 32'hAAAA_AAAA, 2'b00);
    do_read(1'b1, 32'h0000_0100, 3'b011, 5'd0, 1, 0, 0, 32'h0BAD_0100, 2'b00);
    do_read(1'b1, 32'h0000_01FF, 3'b100, 5'd0, 0, 1, 0, 32'h0BAD_01FF, 2'b10);

    // reset in the middle of the data phase
    @(negedge aclk);
    cur_sel   = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_5000;
    cmd_prot  = 3'b001;
    cmd_rready_delay = 5'd0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    check("mid_rready", {63'd0, rready0}, 64'd1);
    #2 areset = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h7777_7777;
    #1;
    check("mid_rst_arvalid", {63'd0, arvalid0}, 64'd0);
    check("mid_rst_rready", {63'd0, rready0}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid0}, 64'd0);
    check("mid_rst_cmd_ready", {63'd0, cmd_ready0}, 64'd0);
    check("mid_rst_araddr", {32'd0, araddr0}, 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    rvalid = 1'b0;
    check("post_rst_no_rsp", {63'd0, rsp_valid0}, 64'd0);
    check("post_rst_cmd_ready", {63'd0, cmd_ready0}, 64'd1);
    do_read(1'b0, 32'h0000_6000, 3'b010, 5'd2, 1, 0, 1, 32'h8888_9999, 2'b00);

    // randomized traffic on both instances
    for (int t = 0; t < 20; t++) begin
      do_read(1'b0, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 3)));
    end
    for (int t = 0; t < 12; t++) begin
      do_read(1'b1, 32'($urandom_range(32'h80, 32'h27F)), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              $urandom, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
